// File: rtl/pinball_pkg.sv
// pinball_pkg: shared ball FSM states, edge-code bit indices and screen size
package pinball_pkg;
    typedef enum logic [1:0] {PARKED, CHARGE, FLIGHT, DRAIN} ball_state_e;
    localparam int EDGE_LEFT   = 0;
    localparam int EDGE_TOP    = 1;
    localparam int EDGE_RIGHT  = 2;
    localparam int EDGE_BOTTOM = 3;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;
endpackage

// File: rtl/ball_controller.sv
// ball_controller: ball FSM, fixed-point physics and collision latches
module ball_controller
    import pinball_pkg::*;
#(
    parameter int START_X        = 560,
    parameter int START_Y        = 400,
    parameter int FRAC           = 6,
    parameter int GRAVITY        = 4,
    parameter int MAX_SPEED      = 1024,
    parameter int LAUNCH_STEP    = 16,
    parameter int LAUNCH_MAX     = 1024,
    parameter int FLIPPER_KICK   = 640,
    parameter int BOTTOM_Y       = 479,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               collisionBorders,
    input  logic               collisionFlipper,
    input  logic        [3:0]  HitEdgeCode,
    input  logic               launchKey,
    input  logic               pause,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic               ballLost,
    output logic               launching
);
    localparam int W  = 11 + FRAC;
    localparam int CW = $clog2(RESPAWN_FRAMES + 1);
    localparam logic signed [W-1:0] SPAWN_X = W'(START_X * (1 << FRAC));
    localparam logic signed [W-1:0] SPAWN_Y = W'(START_Y * (1 << FRAC));
    localparam logic signed [W-1:0] GRAV    = W'(GRAVITY);
    localparam logic signed [W-1:0] MAXS    = W'(MAX_SPEED);
    localparam logic signed [W-1:0] STEP    = W'(LAUNCH_STEP);
    localparam logic signed [W-1:0] LMAX    = W'(LAUNCH_MAX);
    localparam logic signed [W-1:0] KICK    = W'(FLIPPER_KICK);
    localparam logic signed [W-1:0] BOT     = W'(BOTTOM_Y);
    localparam logic [CW-1:0]       LAST    = CW'(RESPAWN_FRAMES - 1);

    ball_state_e        state_q;
    logic signed [W-1:0] px_q, py_q, vx_q, vy_q, charge_q;
    logic signed [W-1:0] vx_r_d, vy_r_d, vx_d, vy_d, px_d, py_d, charge_d;
    logic [CW-1:0]      cnt_q;
    logic [3:0]         border_q;
    logic               flip_q, lost_q, drain_d;
    logic               vx_neg, vx_pos, vy_neg, vy_pos;

    function automatic logic signed [W-1:0] sat(input logic signed [W-1:0] v);
        return v > MAXS ? MAXS : (v < -MAXS ? -MAXS : v);
    endfunction

    // one flight frame: reflect (flipper overrides bottom), gravity, saturate, move
    always_comb begin
        vx_neg   = vx_q[W-1];
        vx_pos   = !vx_q[W-1] && |vx_q;
        vy_neg   = vy_q[W-1];
        vy_pos   = !vy_q[W-1] && |vy_q;
        vx_r_d   = ((border_q[EDGE_LEFT] && vx_neg) || (border_q[EDGE_RIGHT] && vx_pos)) ? -vx_q : vx_q;
        vy_r_d   = (flip_q && vy_pos) ? -KICK :
                   ((border_q[EDGE_TOP] && vy_neg) || (border_q[EDGE_BOTTOM] && vy_pos)) ? -vy_q : vy_q;
        vx_d     = sat(vx_r_d);
        vy_d     = sat(vy_r_d + GRAV);
        px_d     = px_q + vx_d;
        py_d     = py_q + vy_d;
        drain_d  = (py_d >>> FRAC) > BOT;
        charge_d = (charge_q + STEP > LMAX) ? LMAX : charge_q + STEP;
    end

    // state machine and physics registers, advanced once per unpaused frame
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q  <= PARKED;
            px_q     <= SPAWN_X;
            py_q     <= SPAWN_Y;
            vx_q     <= '0;
            vy_q     <= '0;
            charge_q <= '0;
            cnt_q    <= '0;
            lost_q   <= 1'b0;
        end else begin
            lost_q <= 1'b0;
            if (startOfFrame && !pause) begin
                case (state_q)
                    PARKED: begin
                        px_q <= SPAWN_X;
                        py_q <= SPAWN_Y;
                        vx_q <= '0;
                        vy_q <= '0;
                        if (launchKey) begin
                            state_q  <= CHARGE;
                            charge_q <= '0;
                        end
                    end
                    CHARGE: begin
                        if (launchKey) begin
                            charge_q <= charge_d;
                        end else begin
                            state_q <= FLIGHT;
                            vx_q    <= '0;
                            vy_q    <= -charge_q;
                        end
                    end
                    FLIGHT: begin
                        vx_q <= vx_d;
                        vy_q <= vy_d;
                        px_q <= px_d;
                        py_q <= py_d;
                        if (drain_d) begin
                            state_q <= DRAIN;
                            cnt_q   <= '0;
                            lost_q  <= 1'b1;
                        end
                    end
                    DRAIN: begin
                        if (cnt_q == LAST) begin
                            state_q <= PARKED;
                            px_q    <= SPAWN_X;
                            py_q    <= SPAWN_Y;
                            vx_q    <= '0;
                            vy_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= PARKED;
                endcase
            end
        end
    end

    // collision latches: gather hits during flight, drop them when consumed or outside flight
    always_ff @(posedge clk) begin
        if (!resetN || state_q != FLIGHT || (startOfFrame && !pause)) begin
            border_q <= '0;
            flip_q   <= 1'b0;
        end else begin
            border_q <= border_q | (collisionBorders ? HitEdgeCode : 4'b0);
            flip_q   <= flip_q | collisionFlipper;
        end
    end

    assign topLeftX  = px_q[W-1:FRAC];
    assign topLeftY  = py_q[W-1:FRAC];
    assign ballLost  = lost_q;
    assign launching = state_q == CHARGE;
endmodule

// File: rtl/square_object.sv
// square_object: registered pixel-in-rectangle test with pixel offset
module square_object #(
    parameter int OBJ_W = 32,
    parameter int OBJ_H = 32
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic signed [10:0] PixelX,
    input  logic signed [10:0] PixelY,
    input  logic signed [10:0] topLeftX,
    input  logic signed [10:0] topLeftY,
    output logic        [10:0] offsetX,
    output logic        [10:0] offsetY,
    output logic               insideRectangle
);
    localparam logic signed [11:0] OW = 12'(OBJ_W);
    localparam logic signed [11:0] OH = 12'(OBJ_H);
    logic signed [11:0] dx_d, dy_d;
    logic               in_d;
    // pixel distance from the top-left corner, widened so off-screen corners compare correctly
    always_comb begin
        dx_d = {PixelX[10], PixelX} - {topLeftX[10], topLeftX};
        dy_d = {PixelY[10], PixelY} - {topLeftY[10], topLeftY};
        in_d = !dx_d[11] && dx_d < OW && !dy_d[11] && dy_d < OH;
    end
    // register the inside flag and offsets, offsets zeroed outside the box
    always_ff @(posedge clk) begin
        if (!resetN) begin
            insideRectangle <= 1'b0;
            offsetX         <= '0;
            offsetY         <= '0;
        end else begin
            insideRectangle <= in_d;
            offsetX         <= in_d ? dx_d[10:0] : '0;
            offsetY         <= in_d ? dy_d[10:0] : '0;
        end
    end
endmodule

// File: rtl/ball_block.sv
// ball_block: pinball ball object, physics controller plus screen-rectangle test
module ball_block #(
    parameter int OBJ_W          = 32,
    parameter int OBJ_H          = 32,
    parameter int START_X        = 560,
    parameter int START_Y        = 400,
    parameter int FRAC           = 6,
    parameter int GRAVITY        = 4,
    parameter int MAX_SPEED      = 1024,
    parameter int LAUNCH_STEP    = 16,
    parameter int LAUNCH_MAX     = 1024,
    parameter int FLIPPER_KICK   = 640,
    parameter int BOTTOM_Y       = 479,
    parameter int RESPAWN_FRAMES = 60
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic signed [10:0] PixelX,
    input  logic signed [10:0] PixelY,
    input  logic               startOfFrame,
    input  logic               collisionBorders,
    input  logic               collisionFlipper,
    input  logic        [3:0]  HitEdgeCode,
    input  logic               launchKey,
    input  logic               pause,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic        [10:0] offsetX,
    output logic        [10:0] offsetY,
    output logic               insideRectangle,
    output logic               ballLost,
    output logic               launching
);
    ball_controller #(
        .START_X(START_X), .START_Y(START_Y), .FRAC(FRAC), .GRAVITY(GRAVITY),
        .MAX_SPEED(MAX_SPEED), .LAUNCH_STEP(LAUNCH_STEP), .LAUNCH_MAX(LAUNCH_MAX),
        .FLIPPER_KICK(FLIPPER_KICK), .BOTTOM_Y(BOTTOM_Y), .RESPAWN_FRAMES(RESPAWN_FRAMES)
    ) u_ctrl (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .collisionBorders(collisionBorders), .collisionFlipper(collisionFlipper),
        .HitEdgeCode(HitEdgeCode), .launchKey(launchKey), .pause(pause),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .ballLost(ballLost), .launching(launching)
    );

    square_object #(.OBJ_W(OBJ_W), .OBJ_H(OBJ_H)) u_rect (
        .clk(clk), .resetN(resetN), .PixelX(PixelX), .PixelY(PixelY),
        .topLeftX(topLeftX), .topLeftY(topLeftY),
        .offsetX(offsetX), .offsetY(offsetY), .insideRectangle(insideRectangle)
    );
endmodule
